// File: rtl/mcdf_arbiter.sv
// mcdf_arbiter: three-channel priority arbiter with aging boost and tie-break.
// Define ARB_RR_TIEBREAK_EN for round-robin tie-break; otherwise the lowest index wins ties.
module mcdf_arbiter #(
    parameter int unsigned AGE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] slv_prios,
    input  logic [2:0] slv_reqs,
    input  logic       f2a_id_req,
    output logic [2:0] a2s_acks,
    output logic [1:0] a2f_id,
    output logic       a2f_id_val
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } state_t;

    localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);

    state_t          state_q, state_d;
    logic [2:0][3:0] age_q, age_d;
    logic [1:0]      last_grant_q, last_grant_d;
    logic [2:0]      acks_d;
    logic [1:0]      id_d;
    logic            val_d;

    logic [1:0]      win;
    logic [1:0]      scan_ch;
    logic [2:0]      scan_key;
    logic [2:0]      best_key;
    logic            found;

`ifdef ARB_RR_TIEBREAK_EN
    function automatic logic [1:0] rr_chan(input logic [1:0] lg, input int i);
        int unsigned s;
        s = (32'(lg) + 32'd1 + 32'(i)) % 32'd3;
        return s[1:0];
    endfunction
`endif

    // Scan channels in tie-break order; strict '<' keeps the first of equal keys.
    // NOTE: every variable driven here gets a default before any branch, so no latch is inferred.
    always_comb begin
        win      = 2'd0;
        scan_ch  = 2'd0;
        scan_key = 3'b111;
        best_key = 3'b111;
        found    = 1'b0;
        for (int i = 0; i < 3; i++) begin
`ifdef ARB_RR_TIEBREAK_EN
            scan_ch = rr_chan(last_grant_q, i);
`else
            scan_ch = 2'(i);
`endif
            scan_key = {age_q[scan_ch] != AGE_MAX, slv_prios[{scan_ch, 1'b0} +: 2]};
            if (slv_reqs[scan_ch] && (!found || scan_key < best_key)) begin
                found    = 1'b1;
                best_key = scan_key;
                win      = scan_ch;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        age_d        = age_q;
        last_grant_d = last_grant_q;
        acks_d       = 3'b000;
        id_d         = a2f_id;
        val_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (f2a_id_req && slv_reqs != 3'b000) begin
                    state_d      = GRANT;
                    acks_d       = 3'b001 << win;
                    id_d         = win;
                    val_d        = 1'b1;
                    last_grant_d = win;
                    for (int k = 0; k < 3; k++) begin
                        if (2'(k) == win || !slv_reqs[k])
                            age_d[k] = 4'd0;
                        else if (age_q[k] != AGE_MAX)
                            age_d[k] = age_q[k] + 4'd1;
                    end
                end
            end
            GRANT:   state_d = BUSY;
            BUSY:    if (!f2a_id_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            age_q        <= '0;
            last_grant_q <= 2'd2;
            a2s_acks     <= 3'b000;
            a2f_id       <= 2'd0;
            a2f_id_val   <= 1'b0;
        end else begin
            state_q      <= state_d;
            age_q        <= age_d;
            last_grant_q <= last_grant_d;
            a2s_acks     <= acks_d;
            a2f_id       <= id_d;
            a2f_id_val   <= val_d;
        end
    end

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Directed self-checking bench for mcdf_arbiter (AGE_LIMIT = 4).
module tb_mcdf_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] slv_prios;
    logic [2:0] slv_reqs;
    logic       f2a_id_req;
    logic [2:0] a2s_acks;
    logic [1:0] a2f_id;
    logic       a2f_id_val;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ARB_RR_TIEBREAK_EN
    logic [1:0] tie_exp [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
`else
    logic [1:0] tie_exp [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
`endif
    logic [1:0] age_exp [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};

    mcdf_arbiter #(.AGE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .slv_prios  (slv_prios),
        .slv_reqs   (slv_reqs),
        .f2a_id_req (f2a_id_req),
        .a2s_acks   (a2s_acks),
        .a2f_id     (a2f_id),
        .a2f_id_val (a2f_id_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        f2a_id_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Starts in IDLE; request, check the one-cycle grant, then return to IDLE.
    task automatic grant_round(input string tag, input logic [1:0] exp_id);
        f2a_id_req = 1'b1;
        tick();
        check({tag, "_val"}, 32'(a2f_id_val), 32'd1);
        check({tag, "_acks"}, 32'(a2s_acks), 32'(3'b001 << exp_id));
        check({tag, "_id"}, 32'(a2f_id), 32'(exp_id));
        f2a_id_req = 1'b0;
        tick();
        check({tag, "_val_low"}, 32'(a2f_id_val), 32'd0);
        check({tag, "_acks_low"}, 32'(a2s_acks), 32'd0);
        check({tag, "_id_hold"}, 32'(a2f_id), 32'(exp_id));
        tick();
    endtask

    initial begin
        int ack_count;

        // Reset held with requests pending: outputs stay at zero.
        rst        = 1'b1;
        slv_prios  = 6'b00_00_00;
        slv_reqs   = 3'b111;
        f2a_id_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_acks", 32'(a2s_acks), 32'd0);
            check("rst_val", 32'(a2f_id_val), 32'd0);
            check("rst_id", 32'(a2f_id), 32'd0);
        end
        rst = 1'b0;
        tick();
        check("post_rst_val", 32'(a2f_id_val), 32'd1);
        check("post_rst_acks", 32'(a2s_acks), 32'b001);
        f2a_id_req = 1'b0;
        tick();
        tick();

        // Priority: ch0=3, ch1=1, ch2=2 -> ch1 wins.
        apply_reset();
        slv_prios = 6'b10_01_11;
        slv_reqs  = 3'b111;
        grant_round("prio", 2'd1);

        // Tie-break with equal priorities.
        apply_reset();
        slv_prios = 6'b00_00_00;
        slv_reqs  = 3'b111;
        for (int i = 0; i < 6; i++) grant_round($sformatf("tie%0d", i), tie_exp[i]);

        // Aging: ch0 prio 0, ch1 prio 3.
        apply_reset();
        slv_prios = 6'b00_11_00;
        slv_reqs  = 3'b011;
        for (int i = 0; i < 6; i++) grant_round($sformatf("age%0d", i), age_exp[i]);

        // Handshake gating: no formatter request means no ack.
        apply_reset();
        slv_prios  = 6'b00_00_00;
        slv_reqs   = 3'b001;
        f2a_id_req = 1'b0;
        ack_count  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a2s_acks != 3'b000) ack_count++;
        end
        check("gate_noreq_acks", 32'(ack_count), 32'd0);

        // Formatter request held high: exactly one grant.
        f2a_id_req = 1'b1;
        ack_count  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a2s_acks != 3'b000) ack_count++;
        end
        check("gate_held_acks", 32'(ack_count), 32'd1);
        f2a_id_req = 1'b0;
        tick();
        tick();

        // Reset on the IDLE->GRANT edge after building up age state.
        apply_reset();
        slv_prios = 6'b00_00_00;
        slv_reqs  = 3'b111;
        for (int i = 0; i < 5; i++) grant_round($sformatf("pre%0d", i), tie_exp[i]);
        f2a_id_req = 1'b1;
        rst        = 1'b1;
        tick();
        check("midrst_acks", 32'(a2s_acks), 32'd0);
        check("midrst_val", 32'(a2f_id_val), 32'd0);
        check("midrst_id", 32'(a2f_id), 32'd0);
        rst        = 1'b0;
        f2a_id_req = 1'b0;
        tick();
        // Fresh ages and last_grant reproduce the tie sequence from the start.
        for (int i = 0; i < 6; i++) grant_round($sformatf("retie%0d", i), tie_exp[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
